rr_mux_arbiter_4x1: RTL

RR_MUX_ARBITER_4X1 -- requirements
Module: rr_mux_arbiter_4x1

---
 rtl/rr_mux_arbiter_4x1.sv | 91 +++++++++
 1 files changed

// File: rtl/rr_mux_arbiter_4x1.sv
// Four-way round-robin arbiter feeding a single registered output slot.
// A grant is issued only when the slot is empty or being drained this cycle.
module rr_mux_arbiter_4x1 #(
  parameter int unsigned n = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic [n-1:0] d2,
  input  logic [n-1:0] d3,
  output logic [3:0]   gnt,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  output logic [1:0]   out_src,
  input  logic         out_ready
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 2;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  logic          load;
  logic [n-1:0]  win_data;

  // First requester at or after ptr, wrapping modulo four.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[PW'(ptr + PW'(j))]) begin
        found = 1'b1;
        win   = PW'(ptr + PW'(j));
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  assign out_valid = (state == FULL);
  assign load      = found && (!out_valid || out_ready);

  // Reset gates the grant directly so nothing is acknowledged while held.
  always_comb begin
    gnt = 4'b0000;
    if (load && !rst) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY: if (load) state_n = FULL;
      FULL: begin
        if (load)           state_n = FULL;
        else if (out_ready) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_data <= win_data;
      out_src  <= win;
      ptr      <= PW'(win + PW'(1));
    end
  end

endmodule
